// File: rtl/sram_resp_mem.sv
// sram_resp_mem: SRAM-side responder for the core's instruction and data
// sram-like ports. The RAM has a synchronous read and is read-first. It takes
// per-byte writes, and a clear engine fills every word after reset.
// Optional feature: define SRAM_RESP_PARITY_EN to add one even-parity bit per
// stored byte, with parity-error flags on both read ports.
module sram_resp_mem #(
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_W     = $clog2(DEPTH),
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
  parameter bit          CLEAR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        busy,
  input  logic        perr_inject,
  output logic        inst_perr,
  output logic        data_perr
);

  typedef enum logic {StInit, StRun} fsmState_t;

  fsmState_t         state;
  logic [ADDR_W-1:0] clearCnt;
  logic              lastClear;

  logic [ADDR_W-1:0] instIdx;
  logic [ADDR_W-1:0] dataIdx;

  // Single shared write port, driven by either the clear engine or the data port
  logic              wrEn;
  logic [ADDR_W-1:0] wrIdx;
  logic [31:0]       wrData;
  logic [3:0]        wrStrb;

  // Unregistered words at the current read indices (pre-write contents)
  logic [31:0]       instWord;
  logic [31:0]       dataWord;

`ifdef SRAM_RESP_PARITY_EN
  logic [3:0]        wrParFlip;
  logic [3:0]        instLaneErr;
  logic [3:0]        dataLaneErr;
  logic              instPerrQ;
  logic              dataPerrQ;
`endif

  // The low byte-offset bits and the aliased upper bits do not select storage
  logic              unusedBits;

  assign instIdx   = inst_addr[ADDR_W+1:2];
  assign dataIdx   = data_addr[ADDR_W+1:2];
  assign lastClear = (clearCnt == ADDR_W'(DEPTH - 1));

`ifdef SRAM_RESP_PARITY_EN
  assign unusedBits = ^{inst_addr[1:0], inst_addr[31:ADDR_W+2],
                        data_addr[1:0], data_addr[31:ADDR_W+2]};
`else
  assign unusedBits = ^{inst_addr[1:0], inst_addr[31:ADDR_W+2],
                        data_addr[1:0], data_addr[31:ADDR_W+2], perr_inject};
`endif

  // Clear-engine FSM: sweep every word once after reset, then serve requests forever
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR_EN ? StInit : StRun;
      clearCnt <= '0;
      busy     <= CLEAR_EN;
    end else begin
      case (state)
        StInit: begin
          clearCnt <= clearCnt + ADDR_W'(1);
          if (lastClear) begin
            state <= StRun;
            busy  <= 1'b0;
          end
        end
        StRun: begin
          state <= StRun;
        end
        default: begin
          state <= StRun;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write-port select: full-word clear in INIT, strobed store in RUN, nothing during reset
  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = clearCnt;
    wrData = INIT_VALUE;
    wrStrb = '1;
`ifdef SRAM_RESP_PARITY_EN
    wrParFlip = '0;
`endif
    if (!rst) begin
      if (state == StInit) begin
        wrEn = 1'b1;
      end else if (data_en && (data_wen != 4'h0)) begin
        wrEn   = 1'b1;
        wrIdx  = dataIdx;
        wrData = data_wdata;
        wrStrb = data_wen;
`ifdef SRAM_RESP_PARITY_EN
        wrParFlip = perr_inject ? data_wen : 4'h0;
`endif
      end
    end
  end

  // One storage array per byte lane keeps strobed writes free of read-modify-write
  for (genvar g = 0; g < 4; g++) begin : gLane
    logic [7:0] laneMem [DEPTH];

    // Lane write: only when this lane is strobed
    always_ff @(posedge clk) begin
      if (wrEn && wrStrb[g]) begin
        laneMem[wrIdx] <= wrData[8*g +: 8];
      end
    end

    assign instWord[8*g +: 8] = laneMem[instIdx];
    assign dataWord[8*g +: 8] = laneMem[dataIdx];

`ifdef SRAM_RESP_PARITY_EN
    logic laneParMem [DEPTH];

    // Stored bit makes the 9-bit group even; an injected fault flips it
    always_ff @(posedge clk) begin
      if (wrEn && wrStrb[g]) begin
        laneParMem[wrIdx] <= (^wrData[8*g +: 8]) ^ wrParFlip[g];
      end
    end

    assign instLaneErr[g] = (^laneMem[instIdx]) ^ laneParMem[instIdx];
    assign dataLaneErr[g] = (^laneMem[dataIdx]) ^ laneParMem[dataIdx];
`endif
  end

  // Read registers: sample the old word on request in RUN, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata <= '0;
      data_rdata <= '0;
    end else if (state == StRun) begin
      if (inst_en) begin
        inst_rdata <= instWord;
      end
      if (data_en) begin
        data_rdata <= dataWord;
      end
    end
  end

`ifdef SRAM_RESP_PARITY_EN
  // Parity flags are registered alongside the read data they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      instPerrQ <= 1'b0;
      dataPerrQ <= 1'b0;
    end else if (state == StRun) begin
      if (inst_en) begin
        instPerrQ <= |instLaneErr;
      end
      if (data_en) begin
        dataPerrQ <= |dataLaneErr;
      end
    end
  end

  assign inst_perr = instPerrQ;
  assign data_perr = dataPerrQ;
`else
  assign inst_perr = 1'b0;
  assign data_perr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_resp_mem.sv
// tb_sram_resp_mem: randomized and directed checks of sram_resp_mem against a
// word-array model of the memory, its clear sweep, and its per-lane parity state.
module tb_sram_resp_mem;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] INITV = 32'hA5A5_A5A5;
`ifdef SRAM_RESP_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        data_en = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        perr_inject = 1'b0;

  logic [31:0] inst_rdata, data_rdata;
  logic        busy, inst_perr, data_perr;
  logic [31:0] inst_rdata0, data_rdata0;
  logic        busy0, inst_perr0, data_perr0;

  always #5 clk = ~clk;

  sram_resp_mem #(.DEPTH(DEPTH), .INIT_VALUE(INITV), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .busy(busy), .perr_inject(perr_inject),
    .inst_perr(inst_perr), .data_perr(data_perr)
  );

  sram_resp_mem #(.DEPTH(DEPTH), .INIT_VALUE(INITV), .CLEAR_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata0),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata0),
    .busy(busy0), .perr_inject(perr_inject),
    .inst_perr(inst_perr0), .data_perr(data_perr0)
  );

  int unsigned nTests = 0;
  int unsigned nFails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory words, lanes holding bad parity, remaining clear cycles
  logic [31:0] mMem [DEPTH];
  logic [3:0]  mBad [DEPTH];
  int          mRemain = 0;
  int unsigned mCnt = 0;
  bit          mValid = 1'b0;
  logic [31:0] eInst, eData;
  logic        eIP, eDP;

  always @(posedge clk) begin
    int unsigned ii, di;
    logic [31:0] oldD;
    if (rst) begin
      mValid  = 1'b1;
      mRemain = DEPTH;
      mCnt    = 0;
      eInst = '0; eData = '0; eIP = 1'b0; eDP = 1'b0;
    end else if (mValid && mRemain > 0) begin
      mMem[mCnt] = INITV;
      mBad[mCnt] = 4'h0;
      mCnt++;
      mRemain--;
    end else if (mValid) begin
      ii = int'(inst_addr[5:2]);
      di = int'(data_addr[5:2]);
      if (inst_en) begin
        eInst = mMem[ii];
        eIP   = PAR && (mBad[ii] != 4'h0);
      end
      if (data_en) begin
        oldD  = mMem[di];
        eData = oldD;
        eDP   = PAR && (mBad[di] != 4'h0);
        for (int l = 0; l < 4; l++) begin
          if (data_wen[l]) begin
            oldD[8*l +: 8] = data_wdata[8*l +: 8];
            mBad[di][l]    = perr_inject;
          end
        end
        mMem[di] = oldD;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (mValid) begin
      check("busy", 32'(busy), 32'(mRemain > 0));
      check("inst_rdata", inst_rdata, eInst);
      check("data_rdata", data_rdata, eData);
      check("inst_perr", 32'(inst_perr), 32'(eIP));
      check("data_perr", 32'(data_perr), 32'(eDP));
      check("busy_noclear", 32'(busy0), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_en = 1'b0; data_en = 1'b0; data_wen = 4'h0; perr_inject = 1'b0;
  endtask

  task automatic dWrite(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        input logic inj);
    data_en = 1'b1; data_addr = a; data_wen = w; data_wdata = d; perr_inject = inj;
  endtask

  task automatic dRead(input logic [31:0] a);
    data_en = 1'b1; data_addr = a; data_wen = 4'h0; perr_inject = 1'b0;
  endtask

  initial begin
    int unsigned busyCycles;

    // Reset, then writes attempted during the whole clear sweep
    step();
    rst = 1'b0;
    dWrite(32'h04, 4'hF, 32'h1111_1111, 1'b0);
    inst_en = 1'b1; inst_addr = 32'h0;
    busyCycles = 0;
    while (busy === 1'b1 && busyCycles < 100) begin
      check("init_data_zero", data_rdata, 32'h0);
      check("init_inst_zero", inst_rdata, 32'h0);
      step();
      busyCycles++;
    end
    idle();
    check("busy_cycles", busyCycles, 32'd16);
    check("init_end_rdata", data_rdata, 32'h0);

    dRead(32'h3C); step(); idle();
    check("read_3c", data_rdata, 32'hA5A5_A5A5);
    dRead(32'h04); step(); idle();
    check("dropped_write", data_rdata, 32'hA5A5_A5A5);

    // Alias write then partial-lane update
    dWrite(32'h40, 4'hF, 32'hDEAD_BEEF, 1'b0); step();
    dRead(32'h00); step();
    check("alias_read", data_rdata, 32'hDEAD_BEEF);
    dWrite(32'h00, 4'b0010, 32'h0000_AA00, 1'b0); step();
    dRead(32'h00); step(); idle();
    check("lane_write", data_rdata, 32'hDEAD_AAEF);

    // Same-cycle write and fetch of one word
    dWrite(32'h08, 4'hF, 32'h1234_5678, 1'b0);
    inst_en = 1'b1; inst_addr = 32'h08;
    step();
    check("rf_inst_old", inst_rdata, 32'hA5A5_A5A5);
    check("rf_data_old", data_rdata, 32'hA5A5_A5A5);
    idle(); inst_en = 1'b1; inst_addr = 32'h08;
    step(); idle();
    check("rf_inst_new", inst_rdata, 32'h1234_5678);

    // Parity inject, then clean rewrite
    dWrite(32'h0C, 4'hF, 32'hCAFE_F00D, 1'b1); step();
    dRead(32'h0C); inst_en = 1'b1; inst_addr = 32'h0C; step(); idle();
    check("inj_data", data_rdata, 32'hCAFE_F00D);
    check("inj_data_perr", 32'(data_perr), 32'(PAR));
    check("inj_inst_perr", 32'(inst_perr), 32'(PAR));
    dWrite(32'h0C, 4'hF, 32'hCAFE_F00D, 1'b0); step();
    dRead(32'h0C); step(); idle();
    check("clean_perr", 32'(data_perr), 32'd0);

    // Reset mid-sweep at cnt=5; the no-clear instance serves requests at once
    rst = 1'b1; step(); rst = 1'b0;
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rerst_busy", 32'(busy), 32'd1);
    check("noclear_busy", 32'(busy0), 32'd0);
    dWrite(32'h14, 4'hF, 32'h5A5A_1234, 1'b0); step();
    dRead(32'h14); step(); idle();
    busyCycles = 2;
    check("noclear_read", data_rdata0, 32'h5A5A_1234);
    check("busy_read_zero", data_rdata, 32'h0);
    while (busy === 1'b1 && busyCycles < 100) begin
      step();
      busyCycles++;
    end
    check("rerst_busy_cycles", busyCycles, 32'd16);
    dRead(32'h00); step(); idle();
    check("recleared_word0", data_rdata, 32'hA5A5_A5A5);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      inst_en     = 1'($urandom_range(0, 1));
      inst_addr   = $urandom();
      data_en     = 1'($urandom_range(0, 1));
      data_addr   = $urandom();
      data_wen    = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
      data_wdata  = $urandom();
      perr_inject = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
